// File: rtl/fifo_rr_arbiter_if.sv
// Bundle of signals between the round-robin FIFO arbiter and its FIFOs.
// The upstream side carries the empty/data/error flags and the pop strobes.
// The downstream side carries the registered push stream and the pause input.
// The master modport is the arbiter's view. The slave modport is the
// environment's view, i.e. the FIFO bank plus the downstream FIFO.
interface fifo_rr_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 6,
    parameter int PTR_W   = 2
);
    // Upstream FIFO bank -> arbiter
    logic [N_PORTS-1:0]        fifo_empty;
    logic [N_PORTS*DATA_W-1:0] fifo_data;
    logic [N_PORTS-1:0]        fifo_error;

    // Downstream almost-full -> arbiter
    logic                      pause_in;

    // Arbiter -> upstream FIFO bank
    logic [N_PORTS-1:0]        pop;

    // Arbiter -> downstream FIFO
    logic                      push_out;
    logic [DATA_W-1:0]         data_out;
    logic [PTR_W-1:0]          port_id_out;
    logic                      error_out;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  fifo_error,
        input  pause_in,
        output pop,
        output push_out,
        output data_out,
        output port_id_out,
        output error_out
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output fifo_error,
        output pause_in,
        input  pop,
        input  push_out,
        input  data_out,
        input  port_id_out,
        input  error_out
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin consumer of N_PORTS upstream FIFOs.
// - Issues at most one pop per cycle, to the first non-empty FIFO at or after rr_ptr.
// - The popped word arrives one cycle later (registered FIFO read).
// - That word is pushed to the downstream FIFO through a registered output stage.
// - pause_in blocks new pops only; words already in flight still drain.
// - Any fifo_error parks the block in ERROR until reset.
module fifo_rr_arbiter #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 6,
    parameter int PTR_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    fifo_rr_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    // ---------------- state ----------------
    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                s1_valid_q, s1_valid_d;
    logic [PTR_W-1:0]    s1_port_q, s1_port_d;
    logic                push_out_q, push_out_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [PTR_W-1:0]    port_id_q, port_id_d;
    logic                error_out_q, error_out_d;

    // ---------------- combinational helpers ----------------
    logic [N_PORTS-1:0]  req;
    logic [DATA_W-1:0]   port_word [N_PORTS];
    logic                any_req;
    logic                any_err;
    logic                pop_allowed;
    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    cand;
    logic                pop_fire;
    logic [N_PORTS-1:0]  pop_vec;

    assign any_req = |req;
    assign any_err = |bus.fifo_error;

    // Pops stop while in reset, while in ERROR, while paused, and in the very
    // cycle an error is flagged, so a faulty FIFO is never drained further.
    assign pop_allowed = !reset && (state_q != ST_ERROR) && !bus.pause_in
                         && !any_err && any_req;
    assign pop_fire    = pop_allowed && grant_found;

    // Per-port request and word slices, and the one-hot pop decode.
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
        assign req[gi]       = ~bus.fifo_empty[gi];
        assign port_word[gi] = bus.fifo_data[gi*DATA_W +: DATA_W];
        assign pop_vec[gi]   = pop_fire && (grant_idx == PTR_W'(gi));
    end

    // Round-robin search: first requesting port in rr_ptr, rr_ptr+1, ...
    // The candidate index wraps by natural PTR_W overflow (N_PORTS == 2**PTR_W).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = rr_ptr_q + PTR_W'(k);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state decode for the control FSM.
    always_comb begin
        state_d = state_q;
        if (any_err) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req && !bus.pause_in) state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (bus.pause_in)  state_d = ST_PAUSE;
                    else if (!any_req) state_d = ST_IDLE;
                end
                ST_PAUSE: begin
                    if (!bus.pause_in) state_d = any_req ? ST_ACTIVE : ST_IDLE;
                end
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_ERROR;
            endcase
        end
    end

    // Pointer update and the two-stage pop -> push pipeline.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s1_port_d  = s1_port_q;
        data_out_d = data_out_q;
        port_id_d  = port_id_q;

        // Stage 1: remember which FIFO was popped. It drains to zero on an
        // error because pop_fire is already low in that cycle.
        s1_valid_d = pop_fire;
        if (pop_fire) begin
            rr_ptr_d  = grant_idx + PTR_W'(1);
            s1_port_d = grant_idx;
        end

        // Stage 2: the FIFO's registered read data is valid now.
        // A word still in stage 1 when an error appears is discarded.
        push_out_d = s1_valid_q && !any_err;
        if (push_out_d) begin
            data_out_d = port_word[s1_port_q];
            port_id_d  = s1_port_q;
        end

        // Sticky flag that mirrors the ERROR state.
        error_out_d = (state_d == ST_ERROR);
    end

    // All state registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_port_q   <= '0;
            push_out_q  <= 1'b0;
            data_out_q  <= '0;
            port_id_q   <= '0;
            error_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_port_q   <= s1_port_d;
            push_out_q  <= push_out_d;
            data_out_q  <= data_out_d;
            port_id_q   <= port_id_d;
            error_out_q <= error_out_d;
        end
    end

    assign bus.pop         = pop_vec;
    assign bus.push_out    = push_out_q;
    assign bus.data_out    = data_out_q;
    assign bus.port_id_out = port_id_q;
    assign bus.error_out   = error_out_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Testbench for fifo_rr_arbiter.
// - Each upstream FIFO is modelled as a queue with a registered read port.
// - A transaction-level reference model predicts the pops, the push stream and
//   the sticky error from the arbitration rules.
// - Directed scenarios also check hand-computed constants.
module tb_fifo_rr_arbiter;
    localparam int NP = 4;
    localparam int DW = 6;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_rr_arbiter_if #(.N_PORTS(NP), .DATA_W(DW), .PTR_W(PW)) bus ();

    fifo_rr_arbiter #(.N_PORTS(NP), .DATA_W(DW), .PTR_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    // Upstream FIFO environment
    logic [DW-1:0] q [NP][$];
    logic [DW-1:0] rd_data [NP];

    // Stimulus controls
    logic          tb_reset;
    logic          tb_pause;
    logic [NP-1:0] tb_err;

    // Reference model state
    int            m_ptr;
    logic          m_s1_valid;
    logic [DW-1:0] m_s1_data;
    int            m_s1_port;
    logic          m_push;
    logic [DW-1:0] m_data;
    logic [PW-1:0] m_port;
    logic          m_err;

    // Values captured each cycle
    logic [NP-1:0] exp_pop, obs_pop, drv_empty;
    logic          exp_push, obs_push, exp_err, obs_err;
    logic [DW-1:0] exp_data, obs_data;
    logic [PW-1:0] exp_port, obs_port;

    // One clock cycle of environment and model.
    // Inputs are driven on the falling edge, outputs are sampled 1 time unit
    // later, and the FIFO queues and the model advance at the rising edge.
    task automatic tick();
        int gp;
        @(negedge clk);
        reset        = tb_reset;
        bus.pause_in = tb_pause;
        bus.fifo_error = tb_err;
        for (int p = 0; p < NP; p++) begin
            drv_empty[p] = (q[p].size() == 0);
            bus.fifo_data[p*DW +: DW] = rd_data[p];
        end
        bus.fifo_empty = drv_empty;
        #1;
        gp = -1;
        if (!tb_reset && !m_err && !tb_pause && tb_err == '0)
            for (int k = 0; k < NP; k++)
                if (gp < 0 && q[(m_ptr + k) % NP].size() != 0) gp = (m_ptr + k) % NP;
        exp_pop = '0;
        if (gp >= 0) exp_pop[gp] = 1'b1;
        exp_push = m_push; exp_data = m_data; exp_port = m_port; exp_err = m_err;
        obs_pop  = bus.pop; obs_push = bus.push_out; obs_data = bus.data_out;
        obs_port = bus.port_id_out; obs_err = bus.error_out;
        if (obs_push === 1'b1) $display("push port %0d data %h", obs_port, obs_data);
        @(posedge clk);
        if (tb_reset) begin
            m_ptr = 0; m_s1_valid = 1'b0; m_push = 1'b0;
            m_data = '0; m_port = '0; m_err = 1'b0;
        end else begin
            if (m_s1_valid && tb_err == '0) begin
                m_push = 1'b1; m_data = m_s1_data; m_port = PW'(m_s1_port);
            end else begin
                m_push = 1'b0;
            end
            m_s1_valid = (gp >= 0);
            if (gp >= 0) begin
                m_s1_port = gp; m_s1_data = q[gp][0]; m_ptr = (gp + 1) % NP;
            end
            if (tb_err != '0) m_err = 1'b1;
        end
        for (int p = 0; p < NP; p++)
            if (obs_pop[p] === 1'b1 && q[p].size() != 0) rd_data[p] = q[p].pop_front();
    endtask

    task automatic test_reset();
        tb_reset = 1'b1;
        for (int p = 0; p < NP; p++) q[p].push_back(DW'(p + 1));
        tick();
        checks++; if (obs_pop !== '0) $display("FAIL reset_pop_first got %b want 0000", obs_pop); else passes++;
        tick();
        checks++; if (obs_pop !== '0) $display("FAIL reset_pop got %b want 0000", obs_pop); else passes++;
        checks++; if (obs_push !== 1'b0) $display("FAIL reset_push got %b want 0", obs_push); else passes++;
        checks++; if (obs_err !== 1'b0) $display("FAIL reset_error got %b want 0", obs_err); else passes++;
        checks++; if (obs_data !== '0 || obs_port !== '0)
            $display("FAIL reset_data got %h/%0d want 00/0", obs_data, obs_port); else passes++;
        for (int p = 0; p < NP; p++) q[p].delete();
        tb_reset = 1'b0;
    endtask

    task automatic test_single_port();
        logic [DW-1:0] words [4];
        logic [DW+PW-1:0] got [$];
        words = '{6'h11, 6'h16, 6'h30, 6'h1C};
        for (int i = 0; i < 4; i++) q[0].push_back(words[i]);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (obs_pop !== ((i < 4) ? 4'b0001 : 4'b0000))
                $display("FAIL single_pop cycle %0d got %b", i, obs_pop); else passes++;
            checks++; if (obs_pop !== exp_pop)
                $display("FAIL single_pop_model cycle %0d got %b want %b", i, obs_pop, exp_pop); else passes++;
            checks++; if (obs_push !== (i >= 2 && i <= 5))
                $display("FAIL single_push_timing cycle %0d got %b", i, obs_push); else passes++;
            if (obs_push === 1'b1) got.push_back({obs_port, obs_data});
        end
        checks++; if (got.size() != 4) $display("FAIL single_count got %0d want 4", got.size()); else passes++;
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== {2'd0, words[i]})
                $display("FAIL single_word %0d got %h want %h", i, got[i], {2'd0, words[i]}); else passes++;
        end
    endtask

    task automatic test_pause();
        logic [DW-1:0] words [4];
        logic [DW-1:0] got [$];
        int paused_pushes;
        words = '{6'h11, 6'h16, 6'h30, 6'h1C};
        paused_pushes = 0;
        for (int i = 0; i < 4; i++) q[0].push_back(words[i]);
        for (int i = 0; i < 14; i++) begin
            tb_pause = (i >= 2 && i <= 7);
            tick();
            checks++; if (obs_pop !== exp_pop)
                $display("FAIL pause_pop_model cycle %0d got %b want %b", i, obs_pop, exp_pop); else passes++;
            if (i >= 2 && i <= 7) begin
                checks++; if (obs_pop !== 4'b0000) $display("FAIL pause_pop cycle %0d got %b want 0000", i, obs_pop); else passes++;
                if (obs_push === 1'b1) paused_pushes++;
            end
            if (obs_push === 1'b1) got.push_back(obs_data);
        end
        tb_pause = 1'b0;
        checks++; if (paused_pushes != 2) $display("FAIL pause_inflight got %0d want 2", paused_pushes); else passes++;
        checks++; if (got.size() != 4) $display("FAIL pause_total got %0d want 4", got.size()); else passes++;
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== words[i]) $display("FAIL pause_word %0d got %h want %h", i, got[i], words[i]); else passes++;
        end
    endtask

    task automatic test_error();
        logic [DW-1:0] got [$];
        tb_reset = 1'b1; tick(); tb_reset = 1'b0;
        q[0].push_back(6'h21); q[0].push_back(6'h22); q[0].push_back(6'h23);
        q[1].push_back(6'h31); q[1].push_back(6'h32);
        for (int i = 0; i < 8; i++) begin
            tb_err = (i == 2) ? 4'b0010 : 4'b0000;
            tick();
            checks++; if (obs_pop !== exp_pop)
                $display("FAIL error_pop_model cycle %0d got %b want %b", i, obs_pop, exp_pop); else passes++;
            checks++; if (obs_err !== (i >= 3))
                $display("FAIL error_flag cycle %0d got %b want %b", i, obs_err, (i >= 3)); else passes++;
            if (i >= 2) begin
                checks++; if (obs_pop !== 4'b0000) $display("FAIL error_pop cycle %0d got %b want 0000", i, obs_pop); else passes++;
            end
            if (obs_push === 1'b1) got.push_back(obs_data);
        end
        checks++; if (got.size() != 1 || got[0] !== 6'h21)
            $display("FAIL error_drop got %0d pushes first %h want 1 push 21", got.size(), (got.size() > 0) ? got[0] : 6'h00); else passes++;
        tb_reset = 1'b1; tick(); tb_reset = 1'b0;
        tick();
        checks++; if (obs_err !== 1'b0) $display("FAIL error_cleared got %b want 0", obs_err); else passes++;
        checks++; if (obs_pop !== 4'b0001) $display("FAIL error_restart_pop got %b want 0001", obs_pop); else passes++;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (obs_push !== exp_push || (exp_push && obs_data !== exp_data))
                $display("FAIL error_drain_push got %b/%h want %b/%h", obs_push, obs_data, exp_push, exp_data); else passes++;
        end
    endtask

    task automatic test_reset_mid_burst();
        q[2].push_back(6'h0A); q[2].push_back(6'h0B); q[3].push_back(6'h0D);
        tick();
        checks++; if (obs_pop !== exp_pop) $display("FAIL midrst_pop0 got %b want %b", obs_pop, exp_pop); else passes++;
        tb_reset = 1'b1; tick(); tb_reset = 1'b0;
        checks++; if (obs_pop !== 4'b0000) $display("FAIL midrst_pop_in_reset got %b want 0000", obs_pop); else passes++;
        for (int i = 2; i < 9; i++) begin
            tick();
            if (i == 2) begin
                checks++; if (obs_pop !== 4'b0100) $display("FAIL midrst_restart got %b want 0100", obs_pop); else passes++;
            end
            if (i <= 3) begin
                checks++; if (obs_push !== 1'b0) $display("FAIL midrst_no_push cycle %0d got %b want 0", i, obs_push); else passes++;
            end
            checks++; if (obs_pop !== exp_pop || obs_push !== exp_push)
                $display("FAIL midrst_model cycle %0d pop %b/%b push %b/%b", i, obs_pop, exp_pop, obs_push, exp_push); else passes++;
        end
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] order [4];
        logic [DW-1:0] words [4];
        logic [DW+PW-1:0] got [$];
        order = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        words = '{6'h1C, 6'h1D, 6'h1A, 6'h1B};
        tb_reset = 1'b1; tick(); tb_reset = 1'b0;
        q[1].push_back(6'h05);
        for (int i = 0; i < 4; i++) tick();
        q[0].push_back(6'h1A); q[1].push_back(6'h1B); q[2].push_back(6'h1C); q[3].push_back(6'h1D);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i < 4) begin
                checks++; if (obs_pop !== order[i]) $display("FAIL rr_order %0d got %b want %b", i, obs_pop, order[i]); else passes++;
            end
            if (obs_push === 1'b1) got.push_back({obs_port, obs_data});
        end
        checks++; if (got.size() != 4) $display("FAIL rr_count got %0d want 4", got.size()); else passes++;
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== {PW'((i + 2) % NP), words[i]})
                $display("FAIL rr_word %0d got %h want %h", i, got[i], {PW'((i + 2) % NP), words[i]}); else passes++;
        end
        q[1].push_back(6'h07); q[2].push_back(6'h08);
        tick();
        checks++; if (obs_pop !== 4'b0100) $display("FAIL rr_ptr_end got %b want 0100", obs_pop); else passes++;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_random();
        int pops, pushes, drain;
        pops = 0; pushes = 0;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 4) == 0) q[p].push_back(DW'($urandom_range(0, 63)));
            tb_pause = ($urandom_range(0, 4) == 0);
            tick();
            checks++; if (obs_pop !== exp_pop)
                $display("FAIL rand_pop cycle %0d got %b want %b", i, obs_pop, exp_pop); else passes++;
            checks++; if ($countones(obs_pop) > 1 || (obs_pop & drv_empty) != '0)
                $display("FAIL rand_pop_legal cycle %0d got %b empty %b", i, obs_pop, drv_empty); else passes++;
            checks++; if (obs_push !== exp_push || (exp_push && (obs_data !== exp_data || obs_port !== exp_port)))
                $display("FAIL rand_push cycle %0d got %b/%h/%0d want %b/%h/%0d", i, obs_push, obs_data, obs_port, exp_push, exp_data, exp_port); else passes++;
            checks++; if (obs_err !== exp_err) $display("FAIL rand_error cycle %0d got %b want %b", i, obs_err, exp_err); else passes++;
            pops += $countones(obs_pop);
            if (obs_push === 1'b1) pushes++;
        end
        tb_pause = 1'b0;
        drain = 0;
        while (drain < 300 && (q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0) begin
            tick();
            pops += $countones(obs_pop);
            if (obs_push === 1'b1) pushes++;
            drain++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (obs_push === 1'b1) pushes++;
        end
        checks++; if (drain >= 300) $display("FAIL rand_drain_timeout got %0d cycles want <300", drain); else passes++;
        checks++; if (pushes != pops) $display("FAIL rand_conservation got %0d pushes want %0d", pushes, pops); else passes++;
    endtask

    initial begin
        reset = 1'b1; tb_reset = 1'b1; tb_pause = 1'b0; tb_err = '0;
        bus.fifo_empty = '1; bus.fifo_data = '0; bus.fifo_error = '0; bus.pause_in = 1'b0;
        for (int p = 0; p < NP; p++) rd_data[p] = '0;
        m_ptr = 0; m_s1_valid = 1'b0; m_s1_data = '0; m_s1_port = 0;
        m_push = 1'b0; m_data = '0; m_port = '0; m_err = 1'b0;
        test_reset();
        test_single_port();
        test_pause();
        test_error();
        test_reset_mid_burst();
        test_round_robin();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
